// File: rtl/msu_axis_serializer.sv
// msu_axis_serializer: splits one wide word into a little-endian run of
// AXI-stream beats, with tkeep on the final partial beat and tlast on the
// final beat.
// Optional feature macro: MSU_SER_BACK2BACK_EN. When it is defined, a new
// word can be accepted on the same edge as the last beat of the current
// word, so consecutive words stream without a gap.
module msu_axis_serializer #(
  parameter int IN_BITS = 1056,
  parameter int AXI_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_word_val,
  output logic                 s_word_rdy,
  input  logic [IN_BITS-1:0]   s_word_dat,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [AXI_LEN-1:0]   m_axis_tdata,
  output logic [AXI_LEN/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic [31:0]          m_axis_xfer_size_in_bytes,
  output logic                 busy
);

  localparam int BYTS      = AXI_LEN / 8;
  localparam int TOT_BYTS  = (IN_BITS + 7) / 8;
  localparam int NUM_BEATS = (IN_BITS + AXI_LEN - 1) / AXI_LEN;
  localparam int LAST_BYTS = TOT_BYTS - (NUM_BEATS - 1) * BYTS;
  localparam int SR_W      = NUM_BEATS * AXI_LEN;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);

  localparam logic [BYTS-1:0]  FULL_KEEP = '1;
  localparam logic [BYTS-1:0]  LAST_KEEP = FULL_KEEP >> (BYTS - LAST_BYTS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SR_W-1:0]  shift_q;
  logic [SR_W-1:0]  shift_d;
  logic [SR_W-1:0]  load_word;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rdy_q;
  logic             last_beat;
  logic             word_take;

  assign last_beat = (state_q == SEND) && (cnt_q == LAST_CNT);

`ifdef MSU_SER_BACK2BACK_EN
  // Ready also opens while the final beat is being accepted, so the next
  // word can be loaded on the same edge and no idle cycle appears.
  assign s_word_rdy = rdy_q | (last_beat & m_axis_tready);
`else
  assign s_word_rdy = rdy_q;
`endif

  assign word_take = s_word_val & s_word_rdy;

  // Zero-extend the incoming word to a whole number of beats so that the
  // padding above IN_BITS always goes out as zeros.
  always_comb begin
    load_word = '0;
    load_word[IN_BITS-1:0] = s_word_dat;
  end

  // Next-state logic: load on acceptance, shift out one beat per handshake.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (word_take) begin
          shift_d = load_word;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          shift_d = shift_q >> AXI_LEN;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            if (word_take) begin
              shift_d = load_word;
              cnt_d   = '0;
              state_d = SEND;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift register, beat counter and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = shift_q[AXI_LEN-1:0];
  assign m_axis_tkeep  = (state_q != SEND) ? '0 : (last_beat ? LAST_KEEP : FULL_KEEP);
  assign m_axis_tlast  = last_beat;
  assign busy          = (state_q == SEND);
  assign m_axis_xfer_size_in_bytes = 32'(TOT_BYTS);

endmodule
